winewhite_feature_loader: RTL and testbench
===========================================

WINEWHITE_FEATURE_LOADER -- requirements
Module: winewhite_feature_loader

Interface
REQ-001 SHALL have parameter FEAT_CNT, 11, number of features per frame.
REQ-002 SHALL have parameter FEAT_BITS, 4, bits per feature.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 64, idle cycles before a partial frame is abandoned (used only when the timeout feature is compiled in).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: in_valid  in  1  upstream beat valid.
REQ-007 SHALL have port: in_ready  out  1  loader accepts beat.
REQ-008 SHALL have port: in_data  in  FEAT_BITS  one feature per beat.
REQ-009 SHALL have port: in_last  in  1  marks final beat of frame.
REQ-010 SHALL have port: features  out  FEAT_CNT*FEAT_BITS  packed vector to the combinational BNN classifier.
REQ-011 SHALL have port: feat_valid  out  1  features complete and stable.
REQ-012 SHALL have port: feat_ready  in  1  consumer has sampled features/prediction.
REQ-013 SHALL have port: frame_err  out  1  one-cycle pulse on malformed or abandoned frame.

Function
REQ-014 SHALL transfer a beat only when in_valid and in_ready are both high on a rising clk edge.
REQ-015 SHALL pack MSB-first: first accepted beat -> bits [FEAT_CNT*FEAT_BITS-1 -: FEAT_BITS], beat k -> feature FEAT_CNT-1-k, last beat -> bits [FEAT_BITS-1:0].
REQ-016 SHALL implement states LOAD (in_ready=1, feat_valid=0), FULL (in_ready=0, feat_valid=1), DISCARD (in_ready=1, feat_valid=0).
REQ-017 SHALL keep a beat counter 0..FEAT_CNT-1 of width $clog2(FEAT_CNT), cleared on every frame start, error, and reset.
REQ-018 In LOAD, on accepting beat with counter==FEAT_CNT-1 and in_last=1, SHALL enter FULL; feat_valid rises the following cycle (latency 1 cycle from last beat).
REQ-019 In LOAD, on accepting beat with counter==FEAT_CNT-1 and in_last=0, SHALL pulse frame_err and enter DISCARD.
REQ-020 In LOAD, on accepting beat with in_last=1 and counter<FEAT_CNT-1, SHALL pulse frame_err, clear the counter, and remain in LOAD.
REQ-021 In DISCARD, SHALL drop beats until a beat with in_last=1 is accepted, then enter LOAD with counter 0; no further frame_err.
REQ-022 In FULL, features SHALL remain constant; on feat_valid && feat_ready SHALL return to LOAD with in_ready=1 the next cycle; in_valid is ignored in FULL.
REQ-023 Minimum frame period SHALL be FEAT_CNT+1 cycles (FEAT_CNT beats + one FULL cycle with feat_ready=1).
REQ-024 features SHALL be updated only by accepted beats in LOAD; stale bits of an errored frame SHALL be overwritten by the next frame.

Reset
REQ-025 While rst=1: state LOAD, counter 0, features all zero, feat_valid=0, frame_err=0, in_ready=0.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts; reset mid-frame or in FULL SHALL discard the frame without frame_err.

Configuration
REQ-027 With macro LOADER_TIMEOUT_EN defined: an idle counter SHALL count cycles with no accepted beat while in LOAD with counter>0 or in DISCARD; on reaching TIMEOUT_CYCLES, pulse frame_err, clear counter, enter LOAD; counter restarts on every accepted beat.
REQ-028 Without LOADER_TIMEOUT_EN: no idle counter is instantiated; partial frames wait indefinitely; TIMEOUT_CYCLES is unused.

Structure
REQ-029 Package bnn_loader_pkg SHALL hold the state enum (LOAD, FULL, DISCARD) and winewhite defaults (FEAT_CNT=11, FEAT_BITS=4, CLASS_CNT=7).
REQ-030 Timeout logic SHALL be one sub-module, bnn_loader_timer, instantiated only under LOADER_TIMEOUT_EN.

Verification
REQ-031 Stream beats 0x1..0xB, in_last on beat 11, feat_ready=1 -> features=0x123456789AB, feat_valid high exactly one cycle after beat 11.
REQ-032 Same frame, feat_ready held 0 for 5 cycles -> feat_valid and features stable, in_ready=0, no beats consumed, then LOAD after handshake.
REQ-033 in_last on beat 5 -> frame_err one-cycle pulse, no feat_valid; next 11-beat frame 0xFEDCBA98765 delivered intact.
REQ-034 12-beat frame with in_last on beat 12 -> frame_err after beat 11, beat 12 dropped, following good frame delivered.
REQ-035 With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=8: 3 beats then 8 idle cycles -> frame_err, next full frame correct; without macro, same stimulus -> no frame_err, frame completes when beats resume.
REQ-036 Assert rst during beat 6 -> outputs at reset values, no frame_err, next frame delivered correctly.

Source files
------------

// File: rtl/bnn_loader_pkg.sv
// Shared types and wine-white defaults for the BNN feature loader.
package bnn_loader_pkg;

  // Defaults for the wine-white classifier.
  localparam int unsigned WW_FEAT_CNT  = 11;
  localparam int unsigned WW_FEAT_BITS = 4;
  localparam int unsigned WW_CLASS_CNT = 7;

  typedef enum logic [1:0] {
    StLoad    = 2'd0,
    StFull    = 2'd1,
    StDiscard = 2'd2
  } loader_state_e;

endpackage

// File: rtl/winewhite_feature_loader_if.sv
// Beat stream in, packed feature vector out.
// master: upstream source plus feature consumer; slave: the loader.
interface winewhite_feature_loader_if
  import bnn_loader_pkg::*;
#(
  parameter int unsigned FEAT_CNT  = WW_FEAT_CNT,
  parameter int unsigned FEAT_BITS = WW_FEAT_BITS
);

  logic                          in_valid;
  logic                          in_ready;
  logic [FEAT_BITS-1:0]          in_data;
  logic                          in_last;
  logic [FEAT_CNT*FEAT_BITS-1:0] features;
  logic                          feat_valid;
  logic                          feat_ready;
  logic                          frame_err;

  modport master (
    output in_valid, in_data, in_last, feat_ready,
    input  in_ready, features, feat_valid, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, feat_ready,
    output in_ready, features, feat_valid, frame_err
  );

endinterface

// File: rtl/bnn_loader_timer.sv
// Idle-cycle watchdog: expires after TIMEOUT_CYCLES consecutive enabled cycles
// without an accepted beat.
module bnn_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic beat_i,
  output logic expire_o
);

  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_q, idle_d;

  // Expiry on the cycle that would complete the TIMEOUT_CYCLES-th idle cycle.
  always_comb begin
    expire_o = en_i & ~beat_i & (idle_q == IdleLast);
    idle_d   = idle_q + IdleW'(1);
    if (!en_i || beat_i || expire_o) begin
      idle_d = '0;
    end
  end

  // Idle counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/winewhite_feature_loader.sv
// Collects FEAT_CNT beats MSB-first into a packed feature vector and holds it
// for the BNN classifier until the consumer handshakes.
// Optional build macro: LOADER_TIMEOUT_EN adds an idle timeout that abandons
// partial frames after TIMEOUT_CYCLES cycles without a beat.
module winewhite_feature_loader
  import bnn_loader_pkg::*;
#(
  parameter int unsigned FEAT_CNT       = WW_FEAT_CNT,
  parameter int unsigned FEAT_BITS      = WW_FEAT_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  winewhite_feature_loader_if.slave  bus
);

  localparam int unsigned CntW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FEAT_CNT - 1);

  loader_state_e                        state_q;
  logic [CntW-1:0]                      cnt_q;
  logic [FEAT_CNT-1:0][FEAT_BITS-1:0]   feat_q;
  logic                                 feat_valid_q;
  logic                                 frame_err_q;
  logic                                 in_ready_q;

  logic            in_ready;
  logic            beat;
  logic [CntW-1:0] feat_idx;
  logic            timeout;

  // in_ready is forced low combinationally while rst is high so it can be
  // high in the very first cycle after reset is released.
  assign in_ready = in_ready_q & ~rst;
  assign beat     = bus.in_valid & in_ready;
  // Beat k lands in feature FEAT_CNT-1-k, so the first beat is the MSBs.
  assign feat_idx = CntLast - cnt_q;

  assign bus.in_ready   = in_ready;
  assign bus.features   = feat_q;
  assign bus.feat_valid = feat_valid_q;
  assign bus.frame_err  = frame_err_q;

`ifdef LOADER_TIMEOUT_EN
  logic timer_en;

  assign timer_en = ((state_q == StLoad) && (cnt_q != '0)) || (state_q == StDiscard);

  bnn_loader_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (timer_en),
    .beat_i   (beat),
    .expire_o (timeout)
  );
`else
  logic unused_timeout_cycles;

  assign timeout               = 1'b0;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  // Loader FSM with registered handshake and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      cnt_q        <= '0;
      feat_q       <= '0;
      feat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      frame_err_q <= 1'b0;
      if (timeout) begin
        frame_err_q <= 1'b1;
        cnt_q       <= '0;
        state_q     <= StLoad;
        in_ready_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (beat) begin
              feat_q[feat_idx] <= bus.in_data;
              if (cnt_q == CntLast) begin
                cnt_q <= '0;
                if (bus.in_last) begin
                  state_q      <= StFull;
                  feat_valid_q <= 1'b1;
                  in_ready_q   <= 1'b0;
                end else begin
                  // Too many beats: drop the rest of this frame.
                  frame_err_q <= 1'b1;
                  state_q     <= StDiscard;
                end
              end else if (bus.in_last) begin
                // Short frame: restart collection from the next beat.
                frame_err_q <= 1'b1;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end
          end
          StFull: begin
            if (bus.feat_ready) begin
              state_q      <= StLoad;
              feat_valid_q <= 1'b0;
              in_ready_q   <= 1'b1;
            end
          end
          StDiscard: begin
            if (beat && bus.in_last) begin
              state_q <= StLoad;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q    <= StLoad;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_winewhite_feature_loader.sv
// Directed bench for winewhite_feature_loader (FEAT_CNT=11, FEAT_BITS=4,
// TIMEOUT_CYCLES=8). Honours LOADER_TIMEOUT_EN for the idle-timeout case.
module tb_winewhite_feature_loader;

  localparam int unsigned FC = 11;
  localparam int unsigned FB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   err_cnt;
  int   err_base;

  winewhite_feature_loader_if #(.FEAT_CNT(FC), .FEAT_BITS(FB)) bus ();

  winewhite_feature_loader #(
    .FEAT_CNT       (FC),
    .FEAT_BITS      (FB),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [FB-1:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic frame(input logic [FC*FB-1:0] f);
    for (int k = 0; k < FC; k++) begin
      beat(f[FC*FB-1-FB*k -: FB], k == FC - 1);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    err_cnt        = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.feat_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_features", 64'(bus.features), 64'd0);
    check("rst_feat_valid", 64'(bus.feat_valid), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic frame 1..B, consumer always ready.
    for (int k = 1; k <= 10; k++) beat(FB'(k), 1'b0);
    check("basic_no_early_valid", 64'(bus.feat_valid), 64'd0);
    beat(4'hB, 1'b1);
    check("basic_feat_valid", 64'(bus.feat_valid), 64'd1);
    check("basic_features", 64'(bus.features), 64'h123456789AB);
    check("basic_in_ready_full", 64'(bus.in_ready), 64'd0);
    tick();
    check("basic_valid_drop", 64'(bus.feat_valid), 64'd0);
    check("basic_in_ready_back", 64'(bus.in_ready), 64'd1);

    // Backpressure: hold feat_ready low for 5 cycles while upstream pushes.
    bus.feat_ready = 1'b0;
    frame(44'h123456789AB);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_feat_valid", 64'(bus.feat_valid), 64'd1);
      check("bp_features", 64'(bus.features), 64'h123456789AB);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid   = 1'b0;
    bus.feat_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(bus.feat_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);

    // Short frame: in_last on beat 5.
    err_base = err_cnt;
    for (int k = 1; k <= 4; k++) beat(FB'(k), 1'b0);
    beat(4'h5, 1'b1);
    check("short_err_pulse", 64'(bus.frame_err), 64'd1);
    check("short_no_valid", 64'(bus.feat_valid), 64'd0);
    bus.feat_ready = 1'b0;
    beat(4'hF, 1'b0);
    check("short_err_one_cycle", 64'(bus.frame_err), 64'd0);
    for (int k = 1; k < FC; k++) beat(FB'(15 - k), k == FC - 1);
    check("short_next_valid", 64'(bus.feat_valid), 64'd1);
    check("short_next_features", 64'(bus.features), 64'hFEDCBA98765);
    check("short_err_count", 64'(err_cnt - err_base), 64'd1);
    bus.feat_ready = 1'b1;
    tick();

    // Long frame: 12 beats, last on beat 12.
    err_base = err_cnt;
    for (int k = 1; k <= 11; k++) beat(FB'(k), 1'b0);
    check("long_err_pulse", 64'(bus.frame_err), 64'd1);
    check("long_discard_ready", 64'(bus.in_ready), 64'd1);
    beat(4'hC, 1'b1);
    check("long_no_valid", 64'(bus.feat_valid), 64'd0);
    frame(44'hBA987654321);
    check("long_next_valid", 64'(bus.feat_valid), 64'd1);
    check("long_next_features", 64'(bus.features), 64'hBA987654321);
    check("long_err_count", 64'(err_cnt - err_base), 64'd1);
    tick();

    // Idle gap of 8 cycles after 3 beats.
    err_base = err_cnt;
    beat(4'h1, 1'b0);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    for (int i = 0; i < 8; i++) tick();
`ifdef LOADER_TIMEOUT_EN
    check("tmo_err_pulse", 64'(bus.frame_err), 64'd1);
    frame(44'h123456789AB);
    check("tmo_err_count", 64'(err_cnt - err_base), 64'd1);
`else
    check("tmo_no_err", 64'(bus.frame_err), 64'd0);
    for (int k = 4; k <= 11; k++) beat(FB'(k), k == 11);
    check("tmo_err_count", 64'(err_cnt - err_base), 64'd0);
`endif
    check("tmo_frame_valid", 64'(bus.feat_valid), 64'd1);
    check("tmo_frame_features", 64'(bus.features), 64'h123456789AB);
    tick();

    // Reset asserted on beat 6 of a frame.
    err_base = err_cnt;
    for (int k = 1; k <= 5; k++) beat(FB'(k), 1'b0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    tick();
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_features", 64'(bus.features), 64'd0);
    check("midrst_feat_valid", 64'(bus.feat_valid), 64'd0);
    check("midrst_frame_err", 64'(bus.frame_err), 64'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_ready_after", 64'(bus.in_ready), 64'd1);
    frame(44'h2468ACE1357);
    check("midrst_next_valid", 64'(bus.feat_valid), 64'd1);
    check("midrst_next_features", 64'(bus.features), 64'h2468ACE1357);
    check("midrst_err_count", 64'(err_cnt - err_base), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
